// File: rtl/cpu_bus_pkg.sv
// Shared constants for the 24-source CPU bus: driver index map, select width,
// arbiter state encoding and a one-hot helper.
package cpu_bus_pkg;

    localparam int N_SRC = 24;
    localparam int SEL_W = 5;

    localparam int SRC_R0     = 0;
    localparam int SRC_R1     = 1;
    localparam int SRC_R2     = 2;
    localparam int SRC_R3     = 3;
    localparam int SRC_R4     = 4;
    localparam int SRC_R5     = 5;
    localparam int SRC_R6     = 6;
    localparam int SRC_R7     = 7;
    localparam int SRC_R8     = 8;
    localparam int SRC_R9     = 9;
    localparam int SRC_R10    = 10;
    localparam int SRC_R11    = 11;
    localparam int SRC_R12    = 12;
    localparam int SRC_R13    = 13;
    localparam int SRC_R14    = 14;
    localparam int SRC_R15    = 15;
    localparam int SRC_HI     = 16;
    localparam int SRC_LO     = 17;
    localparam int SRC_ZHI    = 18;
    localparam int SRC_ZLO    = 19;
    localparam int SRC_PC     = 20;
    localparam int SRC_MDR    = 21;
    localparam int SRC_INPORT = 22;
    localparam int SRC_C      = 23;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        TURN
    } arb_state_t;

    function automatic logic [N_SRC-1:0] src_onehot(input logic [SEL_W-1:0] idx);
        logic [N_SRC-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Round-robin winner search: first requesting index above last_owner, wrapping
// modulo N_SRC (not modulo 2^SEL_W), so the previous owner ranks last.
module rr_pick
    import cpu_bus_pkg::*;
(
    input  logic [N_SRC-1:0] req,
    input  logic [SEL_W-1:0] last_owner,
    output logic [SEL_W-1:0] winner,
    output logic             any_req
);

    logic [SEL_W:0]   sum;
    logic [SEL_W-1:0] idx;
    logic             found;

    always_comb begin
        winner  = '0;
        any_req = |req;
        found   = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            sum = {1'b0, last_owner} + (SEL_W + 1)'(k);
            if (sum >= (SEL_W + 1)'(N_SRC)) begin
                sum = sum - (SEL_W + 1)'(N_SRC);
            end
            idx = sum[SEL_W-1:0];
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner sequencer for the shared CPU bus with idle turnaround.
// Optional hold-time preemption is compiled in with BUS_ARB_TIMEOUT_EN.
module bus_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int TA_CYC   = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [N_SRC-1:0] req,
    output logic [N_SRC-1:0] grant,
    output logic [SEL_W-1:0] bus_sel,
    output logic             bus_valid,
    output logic             timeout
);

    arb_state_t       state;
    logic [SEL_W-1:0] last_owner;
    logic [SEL_W-1:0] pick_base;
    logic [SEL_W-1:0] winner;
    logic             any_req;
    logic [1:0]       ta_cnt;
    logic             force_rel;
    logic             do_take;
    logic             do_drop;

    if (TA_CYC < 0 || TA_CYC > 3 || MAX_HOLD < 1 || MAX_HOLD > 255 ||
        (1 << SEL_W) < N_SRC) begin : g_param_check
        $error("bus_arbiter: parameter out of legal range");
    end

    // While granted, bus_sel is the owner; ranking from it lets a TA_CYC=0
    // release hand off at the same edge with the old owner ranked last.
    assign pick_base = (state == GRANT) ? bus_sel : last_owner;

    rr_pick u_rr_pick (
        .req        (req),
        .last_owner (pick_base),
        .winner     (winner),
        .any_req    (any_req)
    );

`ifdef BUS_ARB_TIMEOUT_EN
    logic [7:0] hold_cnt;

    assign force_rel = (state == GRANT) && req[bus_sel] &&
                       (hold_cnt >= 8'(MAX_HOLD - 1)) && (|(req & ~grant));
`else
    assign force_rel = 1'b0;
    assign timeout   = 1'b0;
`endif

    always_comb begin
        do_take = 1'b0;
        do_drop = 1'b0;
        case (state)
            IDLE:    do_take = any_req;
            TURN:    do_take = (ta_cnt == 2'd0) && any_req;
            GRANT: begin
                do_drop = !req[bus_sel] || force_rel;
                do_take = !req[bus_sel] && (TA_CYC == 0) && any_req;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state      <= IDLE;
            grant      <= '0;
            bus_sel    <= '0;
            bus_valid  <= 1'b0;
            last_owner <= SEL_W'(N_SRC - 1);
            ta_cnt     <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
            hold_cnt   <= '0;
            timeout    <= 1'b0;
`endif
        end else begin
            if (state == GRANT && do_drop) begin
                last_owner <= bus_sel;
            end
            if (do_take) begin
                state     <= GRANT;
                grant     <= src_onehot(winner);
                bus_sel   <= winner;
                bus_valid <= 1'b1;
            end else if (state == GRANT && do_drop) begin
                grant     <= '0;
                bus_sel   <= '0;
                bus_valid <= 1'b0;
                if (TA_CYC > 0) begin
                    state  <= TURN;
                    ta_cnt <= 2'(TA_CYC - 1);
                end else begin
                    state  <= IDLE;
                end
            end else if (state == TURN) begin
                if (ta_cnt != 2'd0) begin
                    ta_cnt <= ta_cnt - 2'd1;
                end else begin
                    state  <= IDLE;
                end
            end
`ifdef BUS_ARB_TIMEOUT_EN
            timeout <= force_rel;
            if (do_take) begin
                hold_cnt <= '0;
            end else if (state == GRANT && !do_drop && hold_cnt != 8'hFF) begin
                hold_cnt <= hold_cnt + 8'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: two instances (TA_CYC=1 and TA_CYC=0)
// checked every cycle against a per-cycle reference model of ownership.
module tb_bus_arbiter;
    import cpu_bus_pkg::*;

    localparam int MH = 4;

    typedef struct packed {
        logic [N_SRC-1:0] grant;
        logic [SEL_W-1:0] sel;
        logic             valid;
        logic             to;
    } exp_t;

    logic             clk = 1'b0;
    logic             clear;
    logic [N_SRC-1:0] req_a, req_b;
    logic [N_SRC-1:0] grant_a, grant_b;
    logic [SEL_W-1:0] sel_a, sel_b;
    logic             valid_a, valid_b, to_a, to_b;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t qa[$];
    exp_t qb[$];
    int   ord_a[$];
    int   ord_b[$];
    int   want[$];

    int   ta_of[2] = '{1, 0};
    int   m_owner[2];
    int   m_idle[2];
    int   m_last[2];
    int   m_ten[2];
    int   held[N_SRC];
    int   rr_src[3];

    bus_arbiter #(.TA_CYC(1), .MAX_HOLD(MH)) dut_a (
        .clk(clk), .clear(clear), .req(req_a), .grant(grant_a),
        .bus_sel(sel_a), .bus_valid(valid_a), .timeout(to_a)
    );

    bus_arbiter #(.TA_CYC(0), .MAX_HOLD(MH)) dut_b (
        .clk(clk), .clear(clear), .req(req_b), .grant(grant_b),
        .bus_sel(sel_b), .bus_valid(valid_b), .timeout(to_b)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [N_SRC-1:0] r, input int last);
        for (int k = 1; k <= N_SRC; k++) begin
            if (r[(last + k) % N_SRC]) return (last + k) % N_SRC;
        end
        return -1;
    endfunction

    // Ownership after one edge; m_idle counts the mandatory idle cycles left.
    task automatic model_step(input int u, input logic [N_SRC-1:0] r,
                              input logic clr, output exp_t e);
        logic to;
        to = 1'b0;
        if (clr) begin
            m_owner[u] = -1;
            m_idle[u]  = 0;
            m_last[u]  = N_SRC - 1;
        end else if (m_owner[u] >= 0) begin
            if (!r[m_owner[u]]) begin
                m_last[u] = m_owner[u];
                if (ta_of[u] > 0) begin
                    m_owner[u] = -1;
                    m_idle[u]  = ta_of[u];
                end else begin
                    m_owner[u] = pick(r, m_last[u]);
                    m_ten[u]   = 1;
                end
            end
`ifdef BUS_ARB_TIMEOUT_EN
            else if (m_ten[u] >= MH && (r & ~(24'(1) << m_owner[u])) != 0) begin
                to         = 1'b1;
                m_last[u]  = m_owner[u];
                m_owner[u] = -1;
                m_idle[u]  = ta_of[u];
            end else begin
                m_ten[u]++;
            end
`endif
        end else if (m_idle[u] > 1) begin
            m_idle[u]--;
        end else begin
            m_idle[u]  = 0;
            m_owner[u] = pick(r, m_last[u]);
            m_ten[u]   = 1;
        end
        e.grant = (m_owner[u] >= 0) ? (24'(1) << m_owner[u]) : '0;
        e.sel   = (m_owner[u] >= 0) ? SEL_W'(m_owner[u]) : '0;
        e.valid = (m_owner[u] >= 0);
        e.to    = to;
    endtask

    task automatic cyc(input logic [N_SRC-1:0] ra, input logic [N_SRC-1:0] rb,
                       input logic clr);
        exp_t ea, eb;
        req_a = ra;
        req_b = rb;
        clear = clr;
        @(posedge clk);
        model_step(0, ra, clr, ea);
        model_step(1, rb, clr, eb);
        qa.push_back(ea);
        qb.push_back(eb);
        #1;
    endtask

    task automatic wait_owner(input int u, input int who, input logic [N_SRC-1:0] ra,
                              input logic [N_SRC-1:0] rb, input string nm);
        int n;
        n = 0;
        while (m_owner[u] != who && n < 8) begin
            cyc(ra, rb, 1'b0);
            n++;
        end
        if (m_owner[u] != who) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: owner %0d not reached within 8 cycles (model owner %0d)",
                     nm, who, m_owner[u]);
        end
    endtask

    task automatic check_order(input int u, input string nm);
        int  got[$];
        logic ok;
        if (u == 0) got = ord_a;
        else        got = ord_b;
        ok = (got.size() >= want.size());
        for (int i = 0; i < want.size() && ok; i++) begin
            if (got[i] != want[i]) ok = 1'b0;
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL order_%s: owners seen %p, required prefix %p", nm, got, want);
        end
    endtask

    task automatic check_dut(input string nm, input exp_t e, input exp_t act);
        n_cmp++;
        if (act !== e) begin
            n_bad++;
            $display("FAIL %s @%0t: got grant=%h sel=%0d valid=%b to=%b, want grant=%h sel=%0d valid=%b to=%b",
                     nm, $time, act.grant, act.sel, act.valid, act.to,
                     e.grant, e.sel, e.valid, e.to);
        end
        n_cmp++;
        if ($countones(act.grant) > 1) begin
            n_bad++;
            $display("FAIL %s_onehot @%0t: grant=%h has more than one bit, required at most one",
                     nm, $time, act.grant);
        end
    endtask

    // Monitor: pops one expectation per DUT per cycle, samples at the falling edge.
    initial begin
        logic pv_a, pv_b;
        logic [SEL_W-1:0] ps_a, ps_b;
        pv_a = 1'b0;
        pv_b = 1'b0;
        ps_a = '0;
        ps_b = '0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (qa.size() == 0 || qb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL scoreboard @%0t: no expectation queued (qa=%0d qb=%0d), required one",
                         $time, qa.size(), qb.size());
            end else begin
                check_dut("dut_a", qa.pop_front(), {grant_a, sel_a, valid_a, to_a});
                check_dut("dut_b", qb.pop_front(), {grant_b, sel_b, valid_b, to_b});
            end
            if (valid_a && (!pv_a || sel_a != ps_a)) ord_a.push_back(int'(sel_a));
            if (valid_b && (!pv_b || sel_b != ps_b)) ord_b.push_back(int'(sel_b));
            pv_a = valid_a;
            ps_a = sel_a;
            pv_b = valid_b;
            ps_b = sel_b;
        end
    end

    initial begin
        logic [N_SRC-1:0] ra, rb;
        int s;
        rr_src = '{SRC_R3, SRC_PC, SRC_MDR};
        for (int i = 0; i < N_SRC; i++) held[i] = 0;
        m_ten = '{0, 0};

        // reset with everyone requesting, then index 0 wins first
        cyc('1, '1, 1'b1);
        cyc('1, '1, 1'b1);
        cyc('1, '1, 1'b0);
        for (int i = 0; i < 3; i++) cyc('0, '0, 1'b0);

        // round-robin among R3, PC, MDR: 2-cycle tenures, 1-cycle re-raise gap
        ord_a.delete();
        for (int c = 0; c < 14; c++) begin
            ra = '0;
            for (int j = 0; j < 3; j++) begin
                s = rr_src[j];
                if (m_owner[0] == s) begin
                    held[s]++;
                    ra[s] = (held[s] < 2);
                end else begin
                    held[s] = 0;
                    ra[s]   = 1'b1;
                end
            end
            cyc(ra, '0, 1'b0);
        end
        want = {SRC_R3, SRC_PC, SRC_MDR, SRC_R3};
        check_order(0, "round_robin");

        // wrap-around: C releases while R0 and INPORT request
        for (int i = 0; i < 3; i++) cyc('0, '0, 1'b0);
        ord_a.delete();
        wait_owner(0, SRC_C, 24'(1) << SRC_C, '0, "wrap_setup");
        cyc(24'(1) << SRC_C, '0, 1'b0);
        for (int i = 0; i < 4; i++) cyc((24'(1) << SRC_R0) | (24'(1) << SRC_INPORT), '0, 1'b0);
        want = {SRC_C, SRC_R0};
        check_order(0, "wrap");

        // zero-turnaround handoff on dut_b
        for (int i = 0; i < 3; i++) cyc('0, '0, 1'b0);
        ord_b.delete();
        wait_owner(1, SRC_R5, '0, 24'(1) << SRC_R5, "handoff_setup");
        cyc('0, 24'(1) << SRC_R5, 1'b0);
        for (int i = 0; i < 3; i++) cyc('0, 24'(1) << SRC_R9, 1'b0);
        want = {SRC_R5, SRC_R9};
        check_order(1, "handoff");

        // clear while HI owns the bus; arbitration restarts at index 0
        for (int i = 0; i < 3; i++) cyc('0, '0, 1'b0);
        ord_a.delete();
        wait_owner(0, SRC_HI, 24'(1) << SRC_HI, '0, "reset_mid_setup");
        cyc(24'(1) << SRC_HI, '0, 1'b0);
        cyc(24'(1) << SRC_HI, '0, 1'b1);
        for (int i = 0; i < 2; i++) cyc((24'(1) << SRC_HI) | (24'(1) << SRC_R0), '0, 1'b0);
        want = {SRC_HI, SRC_R0};
        check_order(0, "reset_mid");

`ifdef BUS_ARB_TIMEOUT_EN
        // R2 hogs the bus while R7 waits: forced release after MH cycles
        for (int i = 0; i < 3; i++) cyc('0, '0, 1'b0);
        ord_a.delete();
        wait_owner(0, SRC_R2, 24'(1) << SRC_R2, '0, "timeout_setup");
        for (int i = 0; i < 8; i++) cyc((24'(1) << SRC_R2) | (24'(1) << SRC_R7), '0, 1'b0);
        want = {SRC_R2, SRC_R7};
        check_order(0, "timeout");
`endif

        // randomized traffic with occasional clears
        for (int c = 0; c < 400; c++) begin
            ra = 24'($urandom & $urandom);
            rb = 24'($urandom & $urandom & $urandom);
            cyc(ra, rb, $urandom_range(0, 63) == 0);
        end

        cyc('0, '0, 1'b0);
        cyc('0, '0, 1'b0);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Sequences ownership of the shared 32-bit CPU bus among its 24 drivers: R0-R15, HI, LO, Zhigh, Zlow, PC, MDR, InPort, C.
- Arbitrates requests round-robin and drives the one-hot output-enable vector for the driver registers.
- Produces the 5-bit binary select for the bus mux and enforces idle turnaround cycles between owners.
- Sits between the control unit (requesters) and the bus mux/encoder.

Parameters:
- N_SRC, 24, number of bus drivers. Fixed index map: R0-R15=0-15, HI=16, LO=17, Zhigh=18, Zlow=19, PC=20, MDR=21, InPort=22, C=23.
- SEL_W, 5, width of bus_sel; must satisfy 2^SEL_W >= N_SRC.
- TA_CYC, 1, idle bus cycles inserted between owners; legal range 0-3.
- MAX_HOLD, 8, maximum consecutive grant cycles when the timeout feature is compiled in; legal range 1-255.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clear  input  1  synchronous, active-high reset.
- req  input  N_SRC  per-driver bus request; level, held until done.
- grant  output  N_SRC  one-hot output enable (RxOut/HIout/...); all-zero when the bus is idle.
- bus_sel  output  SEL_W  binary index of the current owner; 0 when idle.
- bus_valid  output  1  high when grant is non-zero.
- timeout  output  1  one-cycle pulse on a forced release; tied 0 without the feature.

Behaviour:
- Reset: clear=1 sampled at an edge forces the following, regardless of state (including mid-grant):
  - state=IDLE, grant=0, bus_sel=0, bus_valid=0, timeout=0
  - last_owner=N_SRC-1, so index 0 has top priority after reset
  - ta_cnt=0, hold_cnt=0
- Invariants:
  - grant, bus_sel and bus_valid are registered outputs, mutually consistent every cycle.
  - popcount(grant) <= 1 at all times.
- States:
  - IDLE: if req!=0 at an edge, pick the winner and go to GRANT. grant/bus_sel/bus_valid become valid after that same edge, so latency from req to grant is 1 cycle.
  - GRANT: hold the owner while req[owner]=1. When req[owner]=0 is sampled:
    - grant clears at that edge; last_owner=owner.
    - If TA_CYC>0: go to TURN with ta_cnt=TA_CYC-1.
    - If TA_CYC=0 and another req is pending: hand off directly to the new winner at the same edge (no idle cycle).
    - If TA_CYC=0 and none pending: go to IDLE.
  - TURN: grant=0. Decrement ta_cnt each cycle. At ta_cnt=0, arbitrate as in IDLE (GRANT if any req, else IDLE). Requests arriving during TURN are queued by level only.
- Winner selection:
  - First set bit of req scanning upward from (last_owner+1) mod N_SRC, wrapping.
  - The previous owner therefore has lowest priority. An owner re-requesting immediately after release wins only if no one else is requesting.
- Boundary cases:
  - req all-zero: remain IDLE.
  - Single requester: it wins every time, with TA_CYC gaps between tenures.
  - Wrap-around: last_owner=23 and req[0] set, so index 0 wins.
  - Simultaneous owner drop and new requests: handled as described in GRANT.
  - req bits for indices >= N_SRC (if N_SRC < 2^SEL_W): ignored.
- Arithmetic:
  - The (last_owner+1) mod N_SRC wrap is explicit, not power-of-2 truncation.
  - ta_cnt is 2 bits; hold_cnt is 8 bits and saturates.

Optional Feature:
- Macro: BUS_ARB_TIMEOUT_EN.
- Defined:
  - hold_cnt increments each GRANT cycle and resets on each new grant.
  - When hold_cnt reaches MAX_HOLD-1 with req[owner]=1 and at least one other req set, the owner is force-released at the next edge: grant=0, timeout=1 for exactly one cycle, last_owner=owner.
  - The normal TURN/arbitration path follows, and the preempted owner gets lowest priority.
  - With no other requester, the owner keeps the bus indefinitely and hold_cnt saturates.
- Undefined: no hold_cnt logic; an owner holds the bus as long as its req stays high; timeout is constant 0.

Decomposition:
- Shared package cpu_bus_pkg:
  - N_SRC and SEL_W constants.
  - Named index constants SRC_R0..SRC_R15, SRC_HI, SRC_LO, SRC_ZHI, SRC_ZLO, SRC_PC, SRC_MDR, SRC_INPORT, SRC_C.
  - State enum arb_state_t {IDLE, GRANT, TURN}.
- Sub-module rr_pick (combinational): inputs req and last_owner; outputs the winner index and any_req. Instantiated once.

Test Plan:
- Reset: drive clear=1 for 2 cycles with req=all-ones -> grant=0, bus_sel=0, bus_valid=0. Release clear -> after 1 edge grant=1<<0, bus_sel=0.
- Round-robin: hold req bits 3, 20 (PC) and 21 (MDR) steadily. Each owner drops req after 2 cycles and re-raises 1 cycle later. TA_CYC=1 -> grant order 3, 20, 21, 3, each tenure followed by exactly 1 idle cycle. bus_sel tracks 3, 20, 21.
- Wrap-around: after an owner at index 23 (C) releases, drive req={0,22} -> index 0 wins, bus_sel=0.
- TA_CYC=0 handoff: owner 5 drops req in the same cycle req[9]=1 -> grant switches from 1<<5 to 1<<9 at one edge with no zero cycle. popcount(grant)<=1 every cycle.
- Reset mid-operation: assert clear while owner 16 (HI) holds the bus -> grant=0 after that edge. Next arbitration starts from index 0.
- With BUS_ARB_TIMEOUT_EN and MAX_HOLD=4: owner 2 holds req, req[7]=1 -> grant to 2 lasts 4 cycles, then timeout pulses 1 cycle, then after the turnaround grant goes to 7.
